// File: rtl/inst_fetch_pkg.sv
// Shared widths, fetch FSM encodings and byte/line helpers for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int INST_ADDR_W      = 32;
    localparam int INST_W           = 32;
    localparam int ICACHE_LINES_DEF = 16;

    localparam logic [1:0] IF_IDLE  = 2'd0;
    localparam logic [1:0] IF_FILL  = 2'd1;
    localparam logic [1:0] IF_FLUSH = 2'd2;

    function automatic logic [INST_ADDR_W-1:0] line_base(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

    // Little-endian byte placement: byte 0 lands in bits 7:0.
    function automatic logic [INST_W-1:0] insert_byte(input logic [INST_W-1:0] word,
                                                      input logic [1:0]        pos,
                                                      input logic [7:0]        b);
        logic [INST_W-1:0] w;
        w = word;
        case (pos)
            2'd0:    w[7:0]   = b;
            2'd1:    w[15:8]  = b;
            2'd2:    w[23:16] = b;
            2'd3:    w[31:24] = b;
            default: w        = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped instruction cache: one 32-bit word per line, combinational lookup, synchronous fill.
module icache_dm
    import inst_fetch_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEF,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = INST_ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              hit,
    output logic [INST_W-1:0] rdata,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [INST_W-1:0] wr_data
);

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  valid_d;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    // Next valid vector: a fill sets its line, nothing but reset clears one.
    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[wr_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits are the only cache state that reset touches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data arrays, written only on line completion.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    // Combinational lookup.
    always_comb begin
        hit   = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rdata = data_q[rd_idx];
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, refill FSM over a byte-wide memory port, and the decoder output register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                     ICACHE_LINES = ICACHE_LINES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   misTaken,
    input  logic [INST_ADDR_W-1:0] jumpAddr,
    input  logic                   memGrant,
    input  logic                   memValid,
    input  logic [7:0]             memData,
    output logic                   memRdReq,
    output logic [INST_ADDR_W-1:0] memAddr,
    output logic                   DecEn,
    output logic [INST_ADDR_W-1:0] instPC,
    output logic [INST_W-1:0]      inst
);

    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = INST_ADDR_W - IDX_W - 2;

    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]             state_q, state_d;
    logic [2:0]             req_cnt_q, req_cnt_d;
    logic [1:0]             rx_cnt_q, rx_cnt_d;
    logic [INST_W-1:0]      buf_q, buf_d;
    logic                   dec_en_q, dec_en_d;
    logic [INST_ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [INST_W-1:0]      inst_q, inst_d;
    logic                   mem_rd_req_q, mem_rd_req_d;
    logic [INST_ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic                   hit_s;
    logic [INST_W-1:0]      rdata_s;
    logic                   cache_we_s;
    logic                   grant_s;
    logic                   slot_free_s;

    icache_dm #(
        .LINES (ICACHE_LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_icache (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (pc_q[IDX_W+1:2]),
        .rd_tag  (pc_q[INST_ADDR_W-1:IDX_W+2]),
        .hit     (hit_s),
        .rdata   (rdata_s),
        .we      (cache_we_s),
        .wr_idx  (pc_q[IDX_W+1:2]),
        .wr_tag  (pc_q[INST_ADDR_W-1:IDX_W+2]),
        .wr_data (buf_d)
    );

    // Handshake terms shared by every state.
    always_comb begin
        grant_s     = mem_rd_req_q && memGrant;
        slot_free_s = !dec_en_q || !stall;
    end

    // Next-state logic; a redirect overrides everything, including a completing refill.
    always_comb begin
        pc_d         = pc_q;
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        rx_cnt_d     = rx_cnt_q;
        buf_d        = buf_q;
        dec_en_d     = dec_en_q;
        inst_pc_d    = inst_pc_q;
        inst_d       = inst_q;
        mem_rd_req_d = mem_rd_req_q;
        mem_addr_d   = mem_addr_q;
        cache_we_s   = 1'b0;

        if (misTaken) begin
            pc_d         = jumpAddr & 32'hFFFF_FFFC;
            dec_en_d     = 1'b0;
            mem_rd_req_d = 1'b0;
            req_cnt_d    = 3'd0;
            rx_cnt_d     = 2'd0;
            // A byte granted now still returns next cycle; FLUSH soaks it up.
            if (((state_q == IF_FILL) && grant_s) || (state_q == IF_FLUSH)) begin
                state_d = IF_FLUSH;
            end else begin
                state_d = IF_IDLE;
            end
        end else begin
            case (state_q)
                IF_IDLE: begin
                    if (hit_s) begin
                        if (slot_free_s) begin
                            dec_en_d  = 1'b1;
                            inst_d    = rdata_s;
                            inst_pc_d = pc_q;
                            pc_d      = pc_q + 32'd4;
                        end else begin
                            pc_d = pc_q;
                        end
                    end else begin
                        if (slot_free_s) begin
                            dec_en_d = 1'b0;
                        end else begin
                            dec_en_d = dec_en_q;
                        end
                        state_d      = IF_FILL;
                        mem_rd_req_d = 1'b1;
                        mem_addr_d   = line_base(pc_q);
                        req_cnt_d    = 3'd0;
                        rx_cnt_d     = 2'd0;
                    end
                end
                IF_FILL: begin
                    if (slot_free_s) begin
                        dec_en_d = 1'b0;
                    end else begin
                        dec_en_d = dec_en_q;
                    end
                    if (grant_s) begin
                        req_cnt_d = req_cnt_q + 3'd1;
                        if (req_cnt_d == 3'd4) begin
                            mem_rd_req_d = 1'b0;
                        end else begin
                            mem_addr_d = line_base(pc_q) + {29'd0, req_cnt_d};
                        end
                    end else begin
                        req_cnt_d = req_cnt_q;
                    end
                    if (memValid) begin
                        buf_d = insert_byte(buf_q, rx_cnt_q, memData);
                        if (rx_cnt_q == 2'd3) begin
                            cache_we_s = 1'b1;
                            state_d    = IF_IDLE;
                            rx_cnt_d   = 2'd0;
                            req_cnt_d  = 3'd0;
                        end else begin
                            rx_cnt_d = rx_cnt_q + 2'd1;
                        end
                    end else begin
                        rx_cnt_d = rx_cnt_q;
                    end
                end
                IF_FLUSH: begin
                    if (slot_free_s) begin
                        dec_en_d = 1'b0;
                    end else begin
                        dec_en_d = dec_en_q;
                    end
                    state_d = IF_IDLE;
                end
                default: begin
                    state_d      = IF_IDLE;
                    dec_en_d     = 1'b0;
                    mem_rd_req_d = 1'b0;
                    req_cnt_d    = 3'd0;
                    rx_cnt_d     = 2'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            state_q      <= IF_IDLE;
            req_cnt_q    <= 3'd0;
            rx_cnt_q     <= 2'd0;
            buf_q        <= 32'd0;
            dec_en_q     <= 1'b0;
            inst_pc_q    <= 32'd0;
            inst_q       <= 32'd0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= 32'd0;
        end else begin
            pc_q         <= pc_d;
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            rx_cnt_q     <= rx_cnt_d;
            buf_q        <= buf_d;
            dec_en_q     <= dec_en_d;
            inst_pc_q    <= inst_pc_d;
            inst_q       <= inst_d;
            mem_rd_req_q <= mem_rd_req_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    assign memRdReq = mem_rd_req_q;
    assign memAddr  = mem_addr_q;
    assign DecEn    = dec_en_q;
    assign instPC   = inst_pc_q;
    assign inst     = inst_q;

endmodule
